mac_dot_sequencer: RTL

- Drives the 16-lane pixel/weight MAC from the feeding side and consumes its 20-bit partial sums.
- Fetches one 128-bit pixel vector and one 128-bit weight vector per cycle from synchronous-read buffers and presents them to the MAC.
- Tracks each chunk through the memory and MAC pipelines and accumulates the returned partial sums into one neuron dot product.
- Sits between the image/weight memories and the activation stage of each neuron.

---
 rtl/mac_dot_sequencer_pkg.sv | 22 ++
 rtl/mac_dot_sequencer_valid_tag_pipe.sv | 28 ++
 rtl/mac_dot_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/mac_dot_sequencer_pkg.sv
// Shared constants and FSM state encoding for the MAC dot-product sequencer.
package mac_dot_sequencer_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned LANES     = 16;
   localparam int unsigned SUM_W     = 20;
   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned ACC_W     = SUM_W + CNT_W;
   localparam int unsigned RD_LAT    = 1;
   localparam int unsigned MAC_LAT   = 3;
   localparam int unsigned VEC_W     = LANES * DATA_W;
   localparam int unsigned TAG_DEPTH = RD_LAT + MAC_LAT;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_FINISH
   } state_e;

endpackage

// File: rtl/mac_dot_sequencer_valid_tag_pipe.sv
// Valid-tag shift register tracking issued chunks through the memory and MAC pipelines.
module valid_tag_pipe
   import mac_dot_sequencer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tag_in,
   output logic tag_out,
   output logic pending
);

   logic [TAG_DEPTH-1:0] tag_q;
   logic [TAG_DEPTH-1:0] tag_d;

   always_comb begin
      tag_d = {tag_q[TAG_DEPTH-2:0], tag_in};
   end

   always_ff @(posedge clk) begin
      if (rst) tag_q <= '0;
      else     tag_q <= tag_d;
   end

   assign tag_out = tag_q[TAG_DEPTH-1];
   // Tags still in flight behind the exiting stage; the exiting one is accumulated this cycle.
   assign pending = |tag_q[TAG_DEPTH-2:0];

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds pixel/weight vectors from the buffers to the MAC and accumulates tagged partial sums.
module mac_dot_sequencer
   import mac_dot_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_chunks,
   input  logic [ADDR_W-1:0] pix_base,
   input  logic [ADDR_W-1:0] wgt_base,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              pix_rd,
   input  logic [VEC_W-1:0]  pix_data,
   output logic [ADDR_W-1:0] wgt_addr,
   output logic              wgt_rd,
   input  logic [VEC_W-1:0]  wgt_data,
   output logic [VEC_W-1:0]  mac_pixels,
   output logic [VEC_W-1:0]  mac_weights,
   input  logic [SUM_W-1:0]  mac_sum,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
   logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  result_q, result_d;
   logic              tag_in, tag_out, pending;

   valid_tag_pipe u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out),
      .pending (pending)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pix_addr_d = pix_addr_q;
      wgt_addr_d = wgt_addr_q;
      acc_d      = acc_q;
      result_d   = result_q;

      if (tag_out) acc_d = acc_q + ACC_W'(mac_sum);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_chunks != '0) begin
                  state_d    = ST_ISSUE;
                  cnt_d      = num_chunks;
                  pix_addr_d = pix_base;
                  wgt_addr_d = wgt_base;
                  acc_d      = '0;
               end else begin
                  state_d  = ST_FINISH;
                  result_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            pix_addr_d = pix_addr_q + ADDR_W'(1);
            wgt_addr_d = wgt_addr_q + ADDR_W'(1);
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Result is loaded on the way into FINISH so it is already valid alongside done.
            if (!pending) begin
               state_d  = ST_FINISH;
               result_d = acc_d;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         pix_addr_q <= '0;
         wgt_addr_q <= '0;
         acc_q      <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pix_addr_q <= pix_addr_d;
         wgt_addr_q <= wgt_addr_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
      end
   end

   always_comb begin
      tag_in = (state_q == ST_ISSUE);
      pix_rd = tag_in;
      wgt_rd = tag_in;
      busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
      done   = (state_q == ST_FINISH);
   end

   assign pix_addr    = pix_addr_q;
   assign wgt_addr    = wgt_addr_q;
   assign result      = result_q;
   assign mac_pixels  = pix_data;
   assign mac_weights = wgt_data;

endmodule
